ten_gig_tx_arbiter: RTL and testbench
=====================================

TEN_GIG_TX_ARBITER -- requirements
Module: ten_gig_tx_arbiter

Interface
REQ-001 The block SHALL have parameter P_GAP_CYCLES, default 1, giving the number of idle cycles forced between granted frames (0..15).
REQ-002 The block SHALL have port i_clk, input, 1, the XGMII-domain clock; one clock only.
REQ-003 The block SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have ports s0_axis_tdata/tuser/tkeep/tlast/tvalid, input, 64/32/8/1/1, requester 0 frame stream.
REQ-005 The block SHALL have port s0_axis_tready, output, 1, requester 0 accept.
REQ-006 The block SHALL have ports s1_axis_tdata/tuser/tkeep/tlast/tvalid, input, 64/32/8/1/1, requester 1 frame stream.
REQ-007 The block SHALL have port s1_axis_tready, output, 1, requester 1 accept.
REQ-008 The block SHALL have ports m_axis_tdata/tuser/tkeep/tlast/tvalid, output, 64/32/8/1/1, stream to MAC TX s_axis input.
REQ-009 The block SHALL have port m_axis_tready, input, 1, MAC TX accept.
REQ-010 The block SHALL have port o_grant, output, 2, one-hot current owner (00 = none).

Function
REQ-011 The FSM SHALL have states IDLE, SEND and GAP.
REQ-012 In IDLE, any sN_axis_tvalid SHALL register a grant and move to SEND on the next edge; no data moves in IDLE.
REQ-013 When both requesters are valid in IDLE, the grant SHALL go to the requester not served last (round robin); last-served resets to 1 so requester 0 wins first.
REQ-014 In SEND, the m_axis_* outputs SHALL equal the granted s_axis_* combinationally, with zero added latency.
REQ-015 In SEND, the granted sN_axis_tready SHALL equal m_axis_tready, and the non-granted tready SHALL be 0.
REQ-016 Outside SEND, m_axis_tvalid and both tready outputs SHALL be 0; m_axis data fields SHALL be 0.
REQ-017 Grant SHALL hold for the whole frame; it SHALL release only on a beat with granted tvalid & m_axis_tready & tlast.
REQ-018 On release, last-served SHALL update to the released requester and the FSM SHALL go to GAP, or to IDLE when P_GAP_CYCLES = 0.
REQ-019 GAP SHALL last exactly P_GAP_CYCLES cycles, counted by a 4-bit counter, then return to IDLE.
REQ-020 The granted requester deasserting tvalid mid-frame SHALL keep the grant, with m_axis_tvalid following it to 0.
REQ-021 A single-beat frame (tlast on the first beat) SHALL complete in one SEND cycle.
REQ-022 m_axis_tready low SHALL stall the beat with all m_axis outputs stable; no beat is lost or duplicated.
REQ-023 o_grant SHALL be one-hot of the owner in SEND and 00 otherwise.

Reset
REQ-024 i_rst sampled high SHALL force IDLE, clear the grant, set last-served to 1 and clear the gap counter.
REQ-025 While i_rst is high, all outputs SHALL be 0.
REQ-026 Reset mid-frame SHALL abandon the frame; no resume. Downstream truncation handling is the MAC's responsibility.

Configuration
REQ-027 Macro TEN_GIG_TX_ARB_STRICT_PRIO_EN: when defined, requester 0 SHALL win every IDLE contention and last-served SHALL be ignored; when undefined, round robin per REQ-013 applies.

Verification
REQ-028 Reset release, then s0 sends a 3-beat frame with tready = 1 -> o_grant = 01 one cycle after tvalid, 3 beats pass unchanged, then P_GAP_CYCLES = 1 idle cycle.
REQ-029 s0 and s1 both valid continuously with 2-beat frames -> grants alternate 01, 10, 01, 10; with TEN_GIG_TX_ARB_STRICT_PRIO_EN defined -> always 01.
REQ-030 m_axis_tready toggles 1,0,0,1 during a frame -> m_axis_tdata is held during the stall, granted tready mirrors m_axis_tready, beat count is exact.
REQ-031 s1 is granted, then s0 asserts tvalid mid-frame -> s0_axis_tready = 0 until s1's tlast handshake and the gap complete.
REQ-032 i_rst asserted on the 2nd beat of a 4-beat frame -> the next cycle has o_grant = 00, m_axis_tvalid = 0, and the next arbitration after release favours s0.
REQ-033 P_GAP_CYCLES = 0 with back-to-back single-beat frames from s0 -> the pattern is IDLE, SEND, IDLE, SEND, so one beat is output every two cycles.

Source files
------------

// File: rtl/ten_gig_tx_arbiter.sv
// Two-requester AXI-Stream frame arbiter feeding a 10G MAC TX port, with a configurable idle gap between frames.
// Optional build macro TEN_GIG_TX_ARB_STRICT_PRIO_EN gives requester 0 fixed priority in place of round robin.
module ten_gig_tx_arbiter #(
    parameter int unsigned P_GAP_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] s0_axis_tdata,
    input  logic [31:0] s0_axis_tuser,
    input  logic [7:0]  s0_axis_tkeep,
    input  logic        s0_axis_tlast,
    input  logic        s0_axis_tvalid,
    output logic        s0_axis_tready,
    input  logic [63:0] s1_axis_tdata,
    input  logic [31:0] s1_axis_tuser,
    input  logic [7:0]  s1_axis_tkeep,
    input  logic        s1_axis_tlast,
    input  logic        s1_axis_tvalid,
    output logic        s1_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [31:0] m_axis_tuser,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Final value of the gap counter before returning to IDLE.
    localparam logic [3:0] GAP_LAST = (P_GAP_CYCLES == 0) ? 4'd0 : 4'(P_GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [3:0] gap_q, gap_d;

    logic       pick;
    logic       g_valid;
    logic       g_last;
    logic       send;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
        end
    end

`ifdef TEN_GIG_TX_ARB_STRICT_PRIO_EN
    assign pick = ~s0_axis_tvalid;
`else
    // On contention serve whoever did not go last; otherwise the lone requester.
    assign pick = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_q : s1_axis_tvalid;
`endif

    assign g_valid = sel_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign g_last  = sel_q ? s1_axis_tlast  : s0_axis_tlast;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (s0_axis_tvalid | s1_axis_tvalid) begin
                    state_d = SEND;
                    sel_d   = pick;
                end
            end
            SEND: begin
                if (g_valid & m_axis_tready & g_last) begin
                    last_d  = sel_q;
                    gap_d   = 4'd0;
                    state_d = (P_GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even before the state register clears.
    assign send = (state_q == SEND) & ~i_rst;

    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tuser   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tvalid  = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        o_grant        = 2'b00;
        if (send) begin
            if (sel_q) begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tuser   = s1_axis_tuser;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tvalid  = s1_axis_tvalid;
                s1_axis_tready = m_axis_tready;
                o_grant        = 2'b10;
            end else begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tuser   = s0_axis_tuser;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tvalid  = s0_axis_tvalid;
                s0_axis_tready = m_axis_tready;
                o_grant        = 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_ten_gig_tx_arbiter.sv
// Bench for ten_gig_tx_arbiter: directed vector table, multi-cycle sequences, and a randomized run
// against a per-cycle ownership model for a gap-1 and a gap-0 instance sharing the same inputs.
module tb_ten_gig_tx_arbiter;

`ifdef TEN_GIG_TX_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s0_tdata, s1_tdata;
    logic [31:0] s0_tuser, s1_tuser;
    logic [7:0]  s0_tkeep, s1_tkeep;
    logic        s0_tlast, s1_tlast, s0_tvalid, s1_tvalid, m_tready;

    logic [63:0] a_tdata, z_tdata;
    logic [31:0] a_tuser, z_tuser;
    logic [7:0]  a_tkeep, z_tkeep;
    logic        a_tlast, z_tlast, a_tvalid, z_tvalid;
    logic        a_r0, a_r1, z_r0, z_r1;
    logic [1:0]  a_grant, z_grant;

    always #5 clk = ~clk;

    ten_gig_tx_arbiter #(.P_GAP_CYCLES(1)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
        .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_r0),
        .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
        .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_r1),
        .m_axis_tdata(a_tdata), .m_axis_tuser(a_tuser), .m_axis_tkeep(a_tkeep),
        .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
        .o_grant(a_grant)
    );

    ten_gig_tx_arbiter #(.P_GAP_CYCLES(0)) dut_z (
        .i_clk(clk), .i_rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tkeep(s0_tkeep),
        .s0_axis_tlast(s0_tlast), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(z_r0),
        .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tkeep(s1_tkeep),
        .s1_axis_tlast(s1_tlast), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(z_r1),
        .m_axis_tdata(z_tdata), .m_axis_tuser(z_tuser), .m_axis_tkeep(z_tkeep),
        .m_axis_tlast(z_tlast), .m_axis_tvalid(z_tvalid), .m_axis_tready(m_tready),
        .o_grant(z_grant)
    );

    logic [109:0] act_a, act_z;
    assign act_a = {a_tdata, a_tuser, a_tkeep, a_tlast, a_tvalid, a_r0, a_r1, a_grant};
    assign act_z = {z_tdata, z_tuser, z_tkeep, z_tlast, z_tvalid, z_r0, z_r1, z_grant};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [109:0] act, input logic [109:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [104:0] payload(input int src);
        if (src == 0) return {s0_tdata, s0_tuser, s0_tkeep, s0_tlast};
        if (src == 1) return {s1_tdata, s1_tuser, s1_tkeep, s1_tlast};
        return '0;
    endfunction

    function automatic logic vld(input int src);
        return (src == 0) ? s0_tvalid : s1_tvalid;
    endfunction

    function automatic logic lst(input int src);
        return (src == 0) ? s0_tlast : s1_tlast;
    endfunction

    // Reference: owner (-1 none), remaining forced-idle cycles, and who was served last.
    int owner[2];
    int gap_left[2];
    int served[2];
    int pgap[2] = '{1, 0};

    function automatic logic [109:0] model_out(input int k);
        int o;
        o = owner[k];
        if (rst || o < 0) return '0;
        return {payload(o), vld(o), (o == 0) & m_tready, (o == 1) & m_tready,
                (o == 0) ? 2'b01 : 2'b10};
    endfunction

    task automatic model_step(input int k);
        if (rst) begin
            owner[k] = -1; gap_left[k] = 0; served[k] = 1;
        end else if (owner[k] >= 0) begin
            if (vld(owner[k]) && m_tready && lst(owner[k])) begin
                served[k]   = owner[k];
                owner[k]    = -1;
                gap_left[k] = pgap[k];
            end
        end else if (gap_left[k] > 0) begin
            gap_left[k]--;
        end else if (s0_tvalid && s1_tvalid) begin
            owner[k] = STRICT ? 0 : ((served[k] == 0) ? 1 : 0);
        end else if (s0_tvalid) begin
            owner[k] = 0;
        end else if (s1_tvalid) begin
            owner[k] = 1;
        end
    endtask

    typedef struct {
        logic       rst, v0, l0, v1, l1, mr;
        logic [1:0] g;
        logic       mv, r0, r1;
        int         src;
    } vec_t;

    function automatic vec_t mk(input logic r, v0, l0, v1, l1, mr,
                                input logic [1:0] g, input logic mv, r0, r1, input int src);
        vec_t v;
        v.rst = r; v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1; v.mr = mr;
        v.g = g; v.mv = mv; v.r0 = r0; v.r1 = r1; v.src = src;
        return v;
    endfunction

    vec_t tbl[18];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [109:0] exp;
        logic         pat[5];
        int           beat;
        int           hs;

        rst = 1'b1; m_tready = 1'b0;
        s0_tvalid = 0; s0_tlast = 0; s1_tvalid = 0; s1_tlast = 0;
        s0_tdata = 64'hA0A1_A2A3_A4A5_A6A7; s0_tuser = 32'hA000_0001; s0_tkeep = 8'hFF;
        s1_tdata = 64'hB0B1_B2B3_B4B5_B6B7; s1_tuser = 32'hB000_0002; s1_tkeep = 8'h0F;

        //               rst v0 l0 v1 l1 mr  grant  mv r0 r1 src(-1 none)
        tbl[0]  = mk(1, 1, 0, 0, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[2]  = mk(0, 1, 0, 0, 0, 1, 2'b01, 1, 1, 0,  0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 2'b01, 1, 0, 0,  0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 0,  0);
        tbl[5]  = mk(0, 1, 1, 1, 0, 1, 2'b01, 1, 1, 0,  0);
        tbl[6]  = mk(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[7]  = mk(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        if (STRICT) tbl[8] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 0, 0);
        else        tbl[8] = mk(0, 1, 1, 1, 1, 1, 2'b10, 1, 0, 1, 1);
        tbl[9]  = mk(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[10] = mk(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[11] = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 0,  0);
        tbl[12] = mk(0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[13] = mk(0, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[14] = mk(0, 0, 0, 1, 0, 1, 2'b10, 1, 0, 1,  1);
        tbl[15] = mk(1, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[16] = mk(0, 1, 0, 1, 0, 1, 2'b00, 0, 0, 0, -1);
        tbl[17] = mk(0, 1, 1, 1, 0, 1, 2'b01, 1, 1, 0,  0);

        cyc();
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; s0_tvalid = tbl[i].v0; s0_tlast = tbl[i].l0;
            s1_tvalid = tbl[i].v1; s1_tlast = tbl[i].l1; m_tready = tbl[i].mr;
            #1;
            exp = {payload(tbl[i].src), tbl[i].mv, tbl[i].r0, tbl[i].r1, tbl[i].g};
            check($sformatf("vec%0d", i), act_a, exp);
            cyc();
        end

        // Gap-0 instance: back-to-back single-beat frames give one beat every other cycle.
        rst = 1'b1; s0_tvalid = 0; s1_tvalid = 0; cyc();
        rst = 1'b0; s0_tvalid = 1; s0_tlast = 1; m_tready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("gap0_vld%0d", i), {108'd0, z_grant}, {108'd0, (i % 2 == 1) ? 2'b01 : 2'b00});
            check($sformatf("gap0_mv%0d", i), {109'd0, z_tvalid}, {109'd0, 1'(i % 2)});
            cyc();
        end

        // Stall sequence: ready pattern 1,0,0,1,1 over a 3-beat frame from s0.
        rst = 1'b1; s0_tvalid = 0; cyc();
        rst = 1'b0; s0_tvalid = 1; s0_tlast = 0; s0_tdata = 64'hC000; m_tready = 1;
        #1;
        check("stall_idle_grant", {108'd0, a_grant}, 110'd0);
        cyc();
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        beat = 0; hs = 0;
        for (int i = 0; i < 5; i++) begin
            m_tready = pat[i];
            s0_tdata = 64'hC000 + 64'(beat);
            s0_tlast = (beat == 2);
            #1;
            check($sformatf("stall_data%0d", i), {46'd0, a_tdata}, {46'd0, 64'hC000 + 64'(beat)});
            check($sformatf("stall_rdy%0d", i), {109'd0, a_r0}, {109'd0, pat[i]});
            if (a_tvalid && m_tready && a_r0) hs++;
            if (pat[i]) beat++;
            cyc();
        end
        s0_tvalid = 0;
        #1;
        check("stall_beats", 110'(hs), 110'd3);
        check("stall_release", {108'd0, a_grant}, 110'd0);
        cyc();

        // Randomized run against the ownership model, both instances.
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; gap_left[k] = 0; served[k] = 1;
        end
        for (int c = 0; c < 3000; c++) begin
            rst       = (c == 0) || ($urandom_range(0, 63) == 0);
            s0_tvalid = ($urandom_range(0, 9) < 7);
            s1_tvalid = ($urandom_range(0, 9) < 7);
            s0_tlast  = ($urandom_range(0, 9) < 3);
            s1_tlast  = ($urandom_range(0, 9) < 3);
            m_tready  = ($urandom_range(0, 3) != 0);
            s0_tdata  = {$urandom, $urandom}; s0_tuser = $urandom; s0_tkeep = 8'($urandom);
            s1_tdata  = {$urandom, $urandom}; s1_tuser = $urandom; s1_tkeep = 8'($urandom);
            #1;
            check($sformatf("rand_gap1_c%0d", c), act_a, model_out(0));
            check($sformatf("rand_gap0_c%0d", c), act_z, model_out(1));
            model_step(0);
            model_step(1);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
